// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp
//   Instruction fetch request/response engine with a small circular
//   instruction buffer. It issues at most one outstanding memory read,
//   pushes returned words into the buffer and strobes the fetch unit's
//   PC on every accepted word. A redirect flushes the buffer and
//   squashes any read that is still in flight.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous active-high reset
//   pc         in  32   current fetch address
//   pc_enable  out  1   PC advance strobe (combinational)
//   redirect   in   1   control-flow redirect, flushes everything
//   mem_req    out  1   memory read request, held until mem_ack
//   mem_addr   out 32   word-aligned read address
//   mem_ack    in   1   mem_rdata valid this cycle
//   mem_rdata  in  32   returned instruction word
//   inst_valid out  1   buffer head holds an instruction
//   inst_ready in   1   decode takes the head this cycle
//   inst       out 32   head instruction
//   inst_pc    out 32   head instruction address
//   imm16      out 16   inst[15:0]
//   jmp_imm26  out 26   inst[25:0]
module inst_fetch_resp #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_enable,
  input  logic        redirect,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [15:0] imm16,
  output logic [25:0] jmp_imm26
);

  // DEPTH is 2 or 4, so a pointer of PW bits wraps modulo DEPTH for free.
  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   buf_inst_q [DEPTH];
  logic [31:0]   buf_pc_q   [DEPTH];

  logic push_s;
  logic pop_s;

  // A returned word is kept only when it answers a live (non-squashed) request.
  assign push_s     = (state_q == BUSY) && mem_ack && !redirect;
  assign pop_s      = inst_valid && inst_ready && !redirect;
  assign pc_enable  = redirect || push_s;

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = (count_q != {CW{1'b0}});
  assign inst       = buf_inst_q[head_q];
  assign inst_pc    = buf_pc_q[head_q];
  assign imm16      = inst[15:0];
  assign jmp_imm26  = inst[25:0];

  // Request FSM: issue, wait for ack, or drain a squashed request.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (!redirect && (count_q < DEPTH_C)) begin
          state_d    = BUSY;
          mem_req_d  = 1'b1;
          mem_addr_d = pc & 32'hFFFF_FFFC;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          // Data is either pushed or, under redirect, discarded.
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else if (redirect) begin
          // The request cannot be withdrawn; wait out its ack in DROP.
          state_d = DROP;
        end else begin
          state_d = BUSY;
        end
      end
      DROP: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Buffer pointer and occupancy update; redirect wins over push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      if (push_s) begin
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Buffer storage: word and its fetch address written at the tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_inst_q[i] <= 32'd0;
        buf_pc_q[i]   <= 32'd0;
      end
    end else if (push_s) begin
      buf_inst_q[tail_q] <= mem_rdata;
      buf_pc_q[tail_q]   <= mem_addr_q;
    end
  end

endmodule
